cu_microsequencer: RTL and testbench
====================================

// Module: cu_microsequencer
// PURPOSE
//  Microcode sequencer of the CPU control unit; sits directly upstream of the control-signal field splitter.
//  Holds the micro-PC (upc) and reads the microcode ROM. Drives the registered 62-bit control word that the splitter decodes.
//  Next-address selection uses the word's own cu_adv_sel field: step, opcode dispatch, conditional, or end-of-instruction.
//  Also handles the CB-prefix dispatch, memory-wait stalls and interrupt entry at instruction boundaries.
// PARAMETERS
//  CS_WIDTH        62            control word width
//  UADDR_WIDTH     10            micro-address width (ROM depth 2**UADDR_WIDTH)
//  FETCH_UADDR     10'h000       entry of the common opcode-fetch microroutine
//  CB_FETCH_UADDR  10'h004       entry of the second fetch after a 0xCB prefix
//  IRQ_UADDR       10'h008       entry of the interrupt-push microroutine
//  NOP_WORD        62'h1_0000_0010  idle word: db_nread=1 (bit32), db_nwrite=1 (bit4), all other bits 0
// PORTS
//  clock           in   1    system clock, all state on rising edge
//  reset           in   1    synchronous, active-high
//  inst_opcode     in   8    instruction buffer contents, valid while a dispatch word is current
//  cond_true       in   1    branch condition evaluated from the current flags and opcode
//  mem_ready       in   1    data bus has completed the current read/write
//  irq_pending     in   1    enabled interrupt requested
//  ime             in   1    interrupt master enable
//  control_signals out  62   registered control word for the field splitter
//  upc             out  10   current micro-address (debug/trace)
//  cb_active       out  1    second-level CB dispatch is pending
// BEHAVIOUR
//  Reset (sync, active-high) sets control_signals=NOP_WORD, upc=FETCH_UADDR, cb_active=0 and state=S_BOOT.
//  Reset wins over every other event, including a stall.
//  Pipeline: each advancing cycle does upc<=nxt and control_signals<=rom[nxt].
//   The word is therefore always aligned with upc. Latency from address decision to word is 1 cycle.
//  States:
//   S_BOOT: one NOP cycle, then upc=FETCH_UADDR with its word loaded, go to S_RUN.
//   S_RUN: compute nxt from adv = control_signals[31:30].
//   S_WAIT: hold upc and control_signals unchanged until mem_ready=1, then advance exactly as S_RUN would.
//  Stall condition: current word has db_nread==0 (bit32) or db_nwrite==0 (bit4), and mem_ready==0.
//   Go to or stay in S_WAIT; no other state changes.
//  adv=2'b00: nxt=upc+1. Wrap from 10'h3FF to 10'h000 is permitted but is a microcode bug (assertion).
//  adv=2'b01 (dispatch):
//   cb_active=0 and inst_opcode!=8'hCB: nxt=main_tbl[inst_opcode].
//   cb_active=0 and inst_opcode==8'hCB: nxt=CB_FETCH_UADDR and set cb_active=1.
//   cb_active=1: nxt=cb_tbl[inst_opcode] and clear cb_active.
//  adv=2'b10 (conditional): cond_true=1 gives nxt=upc+1; cond_true=0 gives nxt=FETCH_UADDR. cb_active is cleared.
//  adv=2'b11 (end of instruction): irq_pending&&ime gives nxt=IRQ_UADDR, else nxt=FETCH_UADDR. cb_active is cleared.
//  irq is sampled only on an advancing adv=2'b11 cycle; irq_pending mid-instruction has no effect.
//  A stall on a dispatch word still holds; dispatch resolves using inst_opcode on the cycle the stall releases.
// STRUCTURE
//  Shared package cu_pkg:
//   ADV_NEXT/ADV_DISPATCH/ADV_COND/ADV_END localparams.
//   Bit-index constants CS_ADV_LSB=30, CS_DB_NREAD=32, CS_DB_NWRITE=4.
//   NOP_WORD and the state encoding.
//  Sub-module microcode_rom: combinational lookup with three $readmemh images.
//   Microcode 1024x62, main_tbl 256x10, cb_tbl 256x10.
//   Ports: uaddr -> word, opcode -> main_uaddr/cb_uaddr.
//  This module holds only upc, the control word register, the state and cb_active.
// TESTING
//  1. reset 2 cycles, release -> cycle0 control_signals=NOP_WORD; cycle1 upc=0x000 and word=rom[0]; state S_RUN.
//  2. Words at 0x000..0x002 with adv=00,00,01 and inst_opcode=0x3E, main_tbl[0x3E]=0x120 -> upc sequence 0,1,2,0x120.
//  3. Dispatch with opcode 0xCB -> upc=0x004, cb_active=1.
//     Next dispatch with opcode 0x37, cb_tbl[0x37]=0x300 -> upc=0x300, cb_active=0.
//  4. Word with db_nread=0 and mem_ready=0 for 3 cycles -> upc and control_signals frozen for 3 cycles.
//     mem_ready=1 -> advance next edge.
//  5. adv=10 with cond_true=0 -> upc=0x000; repeat with cond_true=1 at upc=0x050 -> upc=0x051.
//  6. adv=11 with irq_pending=1,ime=1 -> upc=0x008; with ime=0 -> upc=0x000.
//     Assert reset during an S_WAIT stall -> NOP_WORD next cycle, cb_active=0.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared constants for the control-unit microsequencer and its microcode store.
// Latency: none (constants and types only).
// Backpressure: none.
package cu_pkg;

  localparam int CS_WIDTH     = 62;
  localparam int UADDR_WIDTH  = 10;

  // Control-word field positions
  localparam int CS_ADV_LSB   = 30;
  localparam int CS_DB_NREAD  = 32;
  localparam int CS_DB_NWRITE = 4;

  // Next-address selector encodings carried in the control word
  localparam logic [1:0] ADV_NEXT     = 2'b00;
  localparam logic [1:0] ADV_DISPATCH = 2'b01;
  localparam logic [1:0] ADV_COND     = 2'b10;
  localparam logic [1:0] ADV_END      = 2'b11;

  // Fixed microroutine entry points
  localparam logic [UADDR_WIDTH-1:0] FETCH_UADDR    = 10'h000;
  localparam logic [UADDR_WIDTH-1:0] CB_FETCH_UADDR = 10'h004;
  localparam logic [UADDR_WIDTH-1:0] IRQ_UADDR      = 10'h008;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  // Idle word: both bus strobes deasserted (active-low), everything else zero
  localparam logic [CS_WIDTH-1:0] NOP_WORD = 62'h1_0000_0010;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: microcode store plus main and CB-prefix opcode dispatch tables.
// Latency: combinational lookup, 0 cycles.
// Backpressure: none; outputs follow the address and opcode inputs.
module microcode_rom
  import cu_pkg::*;
(
  input  logic [UADDR_WIDTH-1:0] i_uaddr,
  input  logic [7:0]             i_opcode,
  output logic [CS_WIDTH-1:0]    o_word,
  output logic [UADDR_WIDTH-1:0] o_main_uaddr,
  output logic [UADDR_WIDTH-1:0] o_cb_uaddr
);

  // Images are written by the surrounding environment's image loader.
  // Unloaded entries default to idle words / the fetch entry so a blank store stays benign.
  logic [CS_WIDTH-1:0]    rom_ucode    [2**UADDR_WIDTH] = '{default: NOP_WORD};
  logic [UADDR_WIDTH-1:0] rom_main_tbl [256]            = '{default: FETCH_UADDR};
  logic [UADDR_WIDTH-1:0] rom_cb_tbl   [256]            = '{default: FETCH_UADDR};

  assign o_word       = rom_ucode[i_uaddr];
  assign o_main_uaddr = rom_main_tbl[i_opcode];
  assign o_cb_uaddr   = rom_cb_tbl[i_opcode];

endmodule

// File: rtl/cu_microsequencer.sv
// cu_microsequencer: micro-PC and registered control word feeding the field splitter.
// Latency: 1 cycle from next-address decision to word (word always aligned with upc).
// Backpressure: an outstanding bus access (strobe low, mem_ready low) freezes upc and word.
module cu_microsequencer
  import cu_pkg::*;
(
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [7:0]             i_inst_opcode,
  input  logic                   i_cond_true,
  input  logic                   i_mem_ready,
  input  logic                   i_irq_pending,
  input  logic                   i_ime,
  output logic [CS_WIDTH-1:0]    o_control_signals,
  output logic [UADDR_WIDTH-1:0] o_upc,
  output logic                   o_cb_active
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [UADDR_WIDTH-1:0] r_upc;
  logic [UADDR_WIDTH-1:0] w_upc_nxt;
  logic [UADDR_WIDTH-1:0] w_upc_inc;
  logic [UADDR_WIDTH-1:0] w_main_uaddr;
  logic [UADDR_WIDTH-1:0] w_cb_uaddr;
  logic [CS_WIDTH-1:0]    r_cs;
  logic [CS_WIDTH-1:0]    w_word;
  logic                   r_cb_active;
  logic                   w_cb_nxt;
  logic                   w_advance;
  logic                   w_stall;
  logic [1:0]             w_adv;

  assign w_adv     = r_cs[CS_ADV_LSB +: 2];
  assign w_upc_inc = r_upc + 1'b1;
  // Either bus strobe active (low) with the bus not yet done means the access is still in flight
  assign w_stall   = (!r_cs[CS_DB_NREAD] || !r_cs[CS_DB_NWRITE]) && !i_mem_ready;

  microcode_rom u_rom (
    .i_uaddr      (w_upc_nxt),
    .i_opcode     (i_inst_opcode),
    .o_word       (w_word),
    .o_main_uaddr (w_main_uaddr),
    .o_cb_uaddr   (w_cb_uaddr)
  );

  // State register and upc/word/cb pipeline; reset overrides everything, including a stall
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_BOOT;
      r_upc       <= FETCH_UADDR;
      r_cs        <= NOP_WORD;
      r_cb_active <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_advance) begin
        r_upc       <= w_upc_nxt;
        r_cs        <= w_word;
        r_cb_active <= w_cb_nxt;
      end
    end
  end

  // Next state: one idle boot cycle, then run, parking in wait while a bus access is outstanding
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
        w_advance   = 1'b1;
      end
      S_RUN, S_WAIT: begin
        if (w_stall) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_RUN;
          w_advance   = 1'b1;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Next micro-address and CB flag, chosen by the current word's advance selector
  always_comb begin
    w_upc_nxt = FETCH_UADDR;
    w_cb_nxt  = r_cb_active;
    if (r_state != S_BOOT) begin
      case (w_adv)
        ADV_NEXT: w_upc_nxt = w_upc_inc;
        ADV_DISPATCH: begin
          if (r_cb_active) begin
            w_upc_nxt = w_cb_uaddr;
            w_cb_nxt  = 1'b0;
          end else if (i_inst_opcode == CB_PREFIX) begin
            w_upc_nxt = CB_FETCH_UADDR;
            w_cb_nxt  = 1'b1;
          end else begin
            w_upc_nxt = w_main_uaddr;
          end
        end
        ADV_COND: begin
          w_upc_nxt = i_cond_true ? w_upc_inc : FETCH_UADDR;
          w_cb_nxt  = 1'b0;
        end
        default: begin
          // Instruction boundary: the only point where an interrupt is taken
          w_upc_nxt = (i_irq_pending && i_ime) ? IRQ_UADDR : FETCH_UADDR;
          w_cb_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Stepping off the top of the store is a microcode bug
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_advance && r_state != S_BOOT && w_adv == ADV_NEXT) begin
      a_step_wrap: assert (r_upc != {UADDR_WIDTH{1'b1}});
    end
  end

  assign o_control_signals = r_cs;
  assign o_upc             = r_upc;
  assign o_cb_active       = r_cb_active;

endmodule

// File: tb/tb_cu_microsequencer.sv
// tb_cu_microsequencer: directed walk through the sequencing rules, then randomized traffic.
// Expected upc/word/cb come from a behavioural model and are queued per cycle for a separate monitor.
// Directed steps additionally compare against hand-derived constants.
module tb_cu_microsequencer;

  localparam logic [61:0] NOP = 62'h1_0000_0010;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_inst_opcode = 8'h00;
  logic        i_cond_true = 1'b0;
  logic        i_mem_ready = 1'b1;
  logic        i_irq_pending = 1'b0;
  logic        i_ime = 1'b0;
  logic [61:0] o_control_signals;
  logic [9:0]  o_upc;
  logic        o_cb_active;

  always #5 clk = ~clk;

  cu_microsequencer dut (
    .i_clock           (clk),
    .i_reset           (i_reset),
    .i_inst_opcode     (i_inst_opcode),
    .i_cond_true       (i_cond_true),
    .i_mem_ready       (i_mem_ready),
    .i_irq_pending     (i_irq_pending),
    .i_ime             (i_ime),
    .o_control_signals (o_control_signals),
    .o_upc             (o_upc),
    .o_cb_active       (o_cb_active)
  );

  // Bench-side copies of the images
  logic [61:0] ucode    [1024];
  logic [9:0]  main_tbl [256];
  logic [9:0]  cb_tbl   [256];

  typedef struct {
    logic [9:0]  upc;
    logic [61:0] word;
    logic        cb;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: where the sequencer is, whether it is in its idle boot cycle, CB pending
  logic [9:0] m_upc  = 10'h000;
  logic       m_boot = 1'b1;
  logic       m_cb   = 1'b0;

  function automatic logic [61:0] mkword(input logic [1:0] adv, input logic nrd, input logic nwr);
    logic [61:0] w;
    w = {30'($urandom), 32'($urandom)};
    w[31:30] = adv;
    w[32]    = nrd;
    w[4]     = nwr;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One clock of the specified behaviour, expressed directly from the rules
  task automatic model_step(input logic rst, input logic [7:0] op, input logic cond,
                            input logic mr, input logic irq, input logic ie);
    logic [61:0] w;
    exp_t e;
    w = m_boot ? NOP : ucode[m_upc];
    if (rst) begin
      m_boot = 1'b1; m_upc = 10'h000; m_cb = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_upc = 10'h000;
    end else if ((w[32] == 1'b0 || w[4] == 1'b0) && !mr) begin
      // bus access outstanding: nothing moves
    end else begin
      case (w[31:30])
        2'b00: m_upc = m_upc + 10'd1;
        2'b01: begin
          if (m_cb) begin m_upc = cb_tbl[op]; m_cb = 1'b0; end
          else if (op == 8'hCB) begin m_upc = 10'h004; m_cb = 1'b1; end
          else m_upc = main_tbl[op];
        end
        2'b10: begin m_upc = cond ? m_upc + 10'd1 : 10'h000; m_cb = 1'b0; end
        default: begin m_upc = (irq && ie) ? 10'h008 : 10'h000; m_cb = 1'b0; end
      endcase
    end
    e.upc  = m_upc;
    e.word = m_boot ? NOP : ucode[m_upc];
    e.cb   = m_cb;
    q.push_back(e);
  endtask

  task automatic tick(input logic rst, input logic [7:0] op, input logic cond,
                      input logic mr, input logic irq, input logic ie);
    @(negedge clk);
    i_reset = rst; i_inst_opcode = op; i_cond_true = cond;
    i_mem_ready = mr; i_irq_pending = irq; i_ime = ie;
    model_step(rst, op, cond, mr, irq, ie);
  endtask

  // Drive one cycle, then compare the result against hand-derived constants
  task automatic step(input logic rst, input logic [7:0] op, input logic cond, input logic mr,
                      input logic irq, input logic ie, input string nm,
                      input logic [9:0] e_upc, input logic e_cb, input logic e_nop);
    logic [61:0] ew;
    tick(rst, op, cond, mr, irq, ie);
    @(posedge clk); #1;
    ew = e_nop ? NOP : ucode[e_upc];
    chk({nm, "_upc"},  64'(o_upc), 64'(e_upc));
    chk({nm, "_cb"},   64'(o_cb_active), 64'(e_cb));
    chk({nm, "_word"}, 64'(o_control_signals), 64'(ew));
  endtask

  // Monitor: one expectation per clock, compared after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_upc",  64'(o_upc), 64'(e.upc));
        chk("sb_cb",   64'(o_cb_active), 64'(e.cb));
        chk("sb_word", 64'(o_control_signals), 64'(e.word));
      end
    end
  end

  initial begin
    // Random images with directed entries planted on top
    for (int i = 0; i < 1024; i++)
      ucode[i] = mkword(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 256; i++) begin
      main_tbl[i] = 10'($urandom);
      cb_tbl[i]   = 10'($urandom);
    end
    ucode[10'h000] = mkword(2'b00, 1'b1, 1'b1);
    ucode[10'h001] = mkword(2'b00, 1'b1, 1'b1);
    ucode[10'h002] = mkword(2'b01, 1'b1, 1'b1);
    ucode[10'h120] = mkword(2'b01, 1'b1, 1'b1);
    ucode[10'h004] = mkword(2'b01, 1'b0, 1'b1);
    ucode[10'h300] = mkword(2'b00, 1'b0, 1'b1);
    ucode[10'h301] = mkword(2'b10, 1'b1, 1'b1);
    ucode[10'h050] = mkword(2'b10, 1'b1, 1'b1);
    ucode[10'h051] = mkword(2'b11, 1'b1, 1'b1);
    ucode[10'h008] = mkword(2'b11, 1'b1, 1'b1);
    ucode[10'h3FF] = mkword(2'b11, 1'b1, 1'b1);
    main_tbl[8'h3E] = 10'h120;
    main_tbl[8'h50] = 10'h050;
    cb_tbl[8'h37]   = 10'h300;
    for (int i = 0; i < 1024; i++) dut.u_rom.rom_ucode[i] = ucode[i];
    for (int i = 0; i < 256; i++) begin
      dut.u_rom.rom_main_tbl[i] = main_tbl[i];
      dut.u_rom.rom_cb_tbl[i]   = cb_tbl[i];
    end

    //    rst  op     cnd mr irq ie  name             upc     cb nop
    step(1, 8'h00, 0, 1, 0, 0, "reset_a",        10'h000, 0, 1);
    step(1, 8'h00, 0, 1, 0, 0, "reset_b",        10'h000, 0, 1);
    step(0, 8'h00, 0, 1, 0, 0, "boot",           10'h000, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, "step_1",         10'h001, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, "step_2",         10'h002, 0, 0);
    step(0, 8'h3E, 0, 1, 0, 0, "disp_main",      10'h120, 0, 0);
    step(0, 8'hCB, 0, 1, 0, 0, "disp_cb_prefix", 10'h004, 1, 0);
    step(0, 8'h12, 0, 0, 0, 0, "disp_stalled",   10'h004, 1, 0);
    step(0, 8'h37, 0, 1, 0, 0, "disp_cb_tbl",    10'h300, 0, 0);
    step(0, 8'h00, 0, 0, 1, 1, "nread_stall_1",  10'h300, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0, "nread_stall_2",  10'h300, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0, "nread_stall_3",  10'h300, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, "stall_release",  10'h301, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, "cond_false",     10'h000, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, "step_1b",        10'h001, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, "step_2b",        10'h002, 0, 0);
    step(0, 8'h50, 0, 1, 0, 0, "disp_50",        10'h050, 0, 0);
    step(0, 8'h00, 1, 1, 0, 0, "cond_true",      10'h051, 0, 0);
    step(0, 8'h00, 0, 1, 1, 1, "irq_entry",      10'h008, 0, 0);
    step(0, 8'h00, 0, 1, 1, 0, "irq_masked",     10'h000, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, "step_1c",        10'h001, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, "step_2c",        10'h002, 0, 0);
    step(0, 8'hCB, 0, 1, 0, 0, "cb_again",       10'h004, 1, 0);
    step(0, 8'h00, 0, 0, 0, 0, "cb_stalled",     10'h004, 1, 0);
    step(1, 8'h00, 0, 0, 0, 0, "reset_in_wait",  10'h000, 0, 1);
    step(0, 8'h00, 0, 1, 0, 0, "reboot",         10'h000, 0, 0);

    // Randomized traffic, with occasional resets and frequent CB prefixes
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 199) == 0,
           ($urandom_range(0, 7) == 0) ? 8'hCB : 8'($urandom),
           1'($urandom), $urandom_range(0, 2) != 0,
           1'($urandom), 1'($urandom));
    end

    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
